// File: rtl/param_reg_file.sv
// Parametrised register file with per-register clear/load/inc/dec, sticky wrap flags
// and two registered write-through read ports.
module param_reg_file #(
   parameter int              WIDTH     = 8,
   parameter int              NUM_REGS  = 8,
   parameter int              SEL_W     = 3,
   parameter bit              SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Enable,
   input  logic [WIDTH-1:0]    I,
   input  logic [1:0]          FunSel,
   input  logic [NUM_REGS-1:0] RSel,
   input  logic [SEL_W-1:0]    O1Sel,
   input  logic [SEL_W-1:0]    O2Sel,
   output logic [WIDTH-1:0]    O1,
   output logic [WIDTH-1:0]    O2,
   output logic [NUM_REGS-1:0] WrapFlags
);

   typedef enum logic [1:0] {
      FS_CLEAR = 2'b00,
      FS_LOAD  = 2'b01,
      FS_DEC   = 2'b10,
      FS_INC   = 2'b11
   } fun_sel_e;

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] MIN_VAL = '0;

   logic [WIDTH-1:0]    regs      [NUM_REGS];
   logic [WIDTH-1:0]    regs_next [NUM_REGS];
   logic [NUM_REGS-1:0] flags_next;
   logic [WIDTH-1:0]    rd1_next;
   logic [WIDTH-1:0]    rd2_next;
   fun_sel_e            fun_sel;

   assign fun_sel = fun_sel_e'(FunSel);

   // Next state of every register and flag, computed once and shared by the
   // register update and the write-through read ports.
   always_comb begin
      // NOTE: every output of this block is given a default before any branch,
      // so no path leaves a value unassigned and no latch is inferred.
      flags_next = WrapFlags;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_next[k] = regs[k];
         if (Enable && RSel[k]) begin
            unique case (fun_sel)
               FS_CLEAR: begin
                  regs_next[k]  = RESET_VAL;
                  flags_next[k] = 1'b0;
               end
               FS_LOAD: begin
                  regs_next[k]  = I;
                  flags_next[k] = 1'b0;
               end
               FS_DEC: begin
                  if (regs[k] == MIN_VAL) begin
                     regs_next[k]  = SATURATE ? MIN_VAL : MAX_VAL;
                     flags_next[k] = 1'b1;
                  end else begin
                     regs_next[k] = regs[k] - WIDTH'(1);
                  end
               end
               FS_INC: begin
                  if (regs[k] == MAX_VAL) begin
                     regs_next[k]  = SATURATE ? MAX_VAL : MIN_VAL;
                     flags_next[k] = 1'b1;
                  end else begin
                     regs_next[k] = regs[k] + WIDTH'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Index match over the implemented registers only: a select beyond
   // NUM_REGS-1 matches nothing and the port reads zero.
   always_comb begin
      rd1_next = '0;
      rd2_next = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (O1Sel == SEL_W'(k)) rd1_next = regs_next[k];
         if (O2Sel == SEL_W'(k)) rd2_next = regs_next[k];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the register array is reset explicitly; it is a small bank of
      // flops, not a RAM, and downstream logic relies on no X after reset.
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
         WrapFlags <= '0;
         O1        <= RESET_VAL;
         O2        <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= regs_next[k];
         WrapFlags <= flags_next;
         O1        <= rd1_next;
         O2        <= rd2_next;
      end
   end

endmodule
